// File: rtl/writeback_stage.sv
// Writeback stage: a 2-entry result buffer that drains into the integer or FP
// register file. It also keeps a retirement counter and a sticky NaN flag.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_res,
  input  logic [4:0]  in_rd,
  input  logic        in_fp,
  input  logic        in_nan,
  input  logic        rf_busy,
  input  logic        clr_flags,
  output logic        xrf_we,
  output logic        frf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] retire_count,
  output logic        nan_sticky
);

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        fp;
    logic        nan;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // in_ready depends only on registered occupancy, so upstream sees no
  // combinational path from in_valid or rf_busy.
  assign in_ready = (count < 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = (count != 2'd0) & ~rf_busy;
  assign head     = mem[rptr];

  // NOTE: every output gets a default before the conditional code, so no latch is inferred.
  always_comb begin
    xrf_we   = 1'b0;
    frf_we   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (count != 2'd0) begin
      rf_waddr = head.rd;
      rf_wdata = head.res;
      frf_we   = pop & head.fp;
      xrf_we   = pop & ~head.fp & (head.rd != 5'd0);
    end
  end

  // NOTE: the storage array has no reset. count gates every read of it, so
  // stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{res: in_res, rd: in_rd, fp: in_fp, nan: in_nan};
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      count        <= 2'd0;
      retire_count <= '0;
      nan_sticky   <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop) begin
        rptr         <= ~rptr;
        retire_count <= retire_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A set from a NaN retirement takes priority over clr_flags in the same cycle.
      if (pop && head.nan) nan_sticky <= 1'b1;
      else if (clr_flags)  nan_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage. Stimulus queues the register-file writes it expects.
// A negedge monitor pops and compares the queue whenever a write enable is seen.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [4:0]  in_rd;
  logic        in_fp;
  logic        in_nan;
  logic        rf_busy;
  logic        clr_flags;
  logic        xrf_we;
  logic        frf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_count;
  logic        nan_sticky;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  writeback_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_rd        (in_rd),
    .in_fp        (in_fp),
    .in_nan       (in_nan),
    .rf_busy      (rf_busy),
    .clr_flags    (clr_flags),
    .xrf_we       (xrf_we),
    .frf_we       (frf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_count (retire_count),
    .nan_sticky   (nan_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] res, input logic [4:0] rd, input logic fp,
                      input logic nan, input bit expect_write);
    in_valid = 1'b1;
    in_res   = res;
    in_rd    = rd;
    in_fp    = fp;
    in_nan   = nan;
    if (expect_write) exp_q.push_back('{addr: rd, data: res, fp: fp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  // Monitor: every write enable must match the oldest expected write.
  always @(negedge clk) begin
    if (xrf_we || frf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {xrf_we, frf_we}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("we_kind", {30'd0, frf_we, xrf_we}, e.fp ? 32'd2 : 32'd1);
        check("waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
        check("wdata", rf_wdata, e.data);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_res    = '0;
    in_rd     = '0;
    in_fp     = 1'b0;
    in_nan    = 1'b0;
    rf_busy   = 1'b0;
    clr_flags = 1'b0;
    #12;
    check("rst_retire", retire_count, 32'd0);
    check("rst_nan", {31'd0, nan_sticky}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Single integer write.
    send(32'h0000_00AB, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("int_retire", retire_count, 32'd1);
    check("idle_waddr", {27'd0, rf_waddr}, 32'd0);
    check("idle_wdata", rf_wdata, 32'd0);

    // A write to x0 is suppressed but still retires.
    do_reset();
    send(32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("x0_retire", retire_count, 32'd1);

    // Backpressure fill: a third result is refused, then both drain in order.
    do_reset();
    rf_busy = 1'b1;
    send(32'h0000_0011, 5'd7, 1'b0, 1'b0, 1'b1);
    step();
    send(32'h0000_0022, 5'd8, 1'b1, 1'b0, 1'b1);
    step();
    check("full_not_ready", {31'd0, in_ready}, 32'd0);
    send(32'h0000_0033, 5'd9, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("busy_head_addr", {27'd0, rf_waddr}, 32'd7);
    check("busy_head_data", rf_wdata, 32'h0000_0011);
    check("busy_no_we", {30'd0, xrf_we, frf_we}, 32'd0);
    step(2);
    check("busy_hold_addr", {27'd0, rf_waddr}, 32'd7);
    check("busy_retire", retire_count, 32'd0);
    rf_busy = 1'b0;
    step(2);
    check("drain_ready", {31'd0, in_ready}, 32'd1);
    check("drain_retire", retire_count, 32'd2);
    step(2);
    check("drain_empty_q", exp_q.size(), 32'd0);

    // Sticky NaN: set on a NaN pop, set beats clear, clear alone clears.
    do_reset();
    send(32'h7FC0_0000, 5'd3, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("nan_set", {31'd0, nan_sticky}, 32'd1);
    send(32'h7FC0_0001, 5'd4, 1'b1, 1'b1, 1'b1);
    step();
    in_valid  = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("nan_set_wins", {31'd0, nan_sticky}, 32'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("nan_cleared", {31'd0, nan_sticky}, 32'd0);
    send(32'h3F80_0000, 5'd6, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("nan_not_set", {31'd0, nan_sticky}, 32'd0);
    check("nan_retire", retire_count, 32'd3);

    // Retirement counter wrap.
    do_reset();
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    send(32'h0000_0055, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("retire_wrap", retire_count, 32'd0);

    // Asynchronous reset with two buffered entries.
    do_reset();
    rf_busy = 1'b1;
    send(32'h0000_0066, 5'd10, 1'b0, 1'b0, 1'b0);
    step();
    send(32'h0000_0077, 5'd11, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("pre_rst_addr", {27'd0, rf_waddr}, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_addr", {27'd0, rf_waddr}, 32'd0);
    check("async_rst_data", rf_wdata, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    rf_busy = 1'b0;
    #1;
    check("rst_no_we", {30'd0, xrf_we, frf_we}, 32'd0);
    step(2);
    reset = 1'b0;
    step(3);
    check("no_stale_retire", retire_count, 32'd0);
    check("final_empty_q", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  in  1  execution result presented.
REQ-004 SHALL have port: in_ready  out  1  stage can accept a result this cycle.
REQ-005 SHALL have port: in_res  in  32  result word from the execution unit (ALU or FPU).
REQ-006 SHALL have port: in_rd  in  5  destination register index.
REQ-007 SHALL have port: in_fp  in  1  1 = FP register file target, 0 = integer register file target.
REQ-008 SHALL have port: in_nan  in  1  FPU NaN flag for this result.
REQ-009 SHALL have port: rf_busy  in  1  register-file write port unavailable this cycle.
REQ-010 SHALL have port: clr_flags  in  1  clear sticky NaN flag.
REQ-011 SHALL have port: xrf_we  out  1  integer register-file write enable.
REQ-012 SHALL have port: frf_we  out  1  FP register-file write enable.
REQ-013 SHALL have port: rf_waddr  out  5  write address, shared by both files.
REQ-014 SHALL have port: rf_wdata  out  32  write data, shared by both files.
REQ-015 SHALL have port: retire_count  out  32  count of retired results.
REQ-016 SHALL have port: nan_sticky  out  1  sticky NaN flag.
REQ-017 SHALL have parameter: none; depth is fixed at 2 entries.

Function
REQ-018 SHALL buffer results in a 2-entry FIFO of {res, rd, fp, nan}, with 1-bit read/write pointers and a 2-bit occupancy count.
REQ-019 SHALL drive in_ready = (count < 2), a function of registered state only, with no combinational path from in_valid or rf_busy.
REQ-020 SHALL push when in_valid & in_ready, storing at wptr; wptr toggles.
REQ-021 SHALL pop when count > 0 & !rf_busy; rptr toggles.
REQ-022 SHALL update count as: push only +1; pop only -1; push and pop together unchanged.
REQ-023 SHALL drive the write outputs combinationally from the head entry: rf_waddr = head.rd, rf_wdata = head.res.
REQ-024 SHALL assert frf_we = pop & head.fp.
REQ-025 SHALL assert xrf_we = pop & !head.fp & (head.rd != 0); a pop to integer x0 writes nothing but still retires.
REQ-026 SHALL present rf_waddr = 0 and rf_wdata = 0 when count == 0.
REQ-027 SHALL have minimum latency of 1 cycle: a result pushed in cycle N can be written in cycle N+1; there is no flow-through path in the same cycle.
REQ-028 SHALL increment retire_count by 1 on every pop, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-029 SHALL set nan_sticky on a pop with head.nan = 1.
REQ-030 SHALL clear nan_sticky on clr_flags; when set and clear occur in the same cycle, set wins.
REQ-031 SHALL preserve the head entry and all outputs unchanged while rf_busy = 1 holds across any number of cycles.
REQ-032 SHALL ignore in_valid while in_ready = 0: no state change and no data loss of already-buffered entries.

Reset
REQ-033 SHALL, on reset assertion, immediately force count = 0, both pointers = 0, retire_count = 0, nan_sticky = 0, xrf_we = frf_we = 0, rf_waddr = 0 and rf_wdata = 0, regardless of clk.
REQ-034 SHALL discard buffered entries when reset is asserted mid-operation; no write enable may be asserted while reset is high.
REQ-035 SHALL drive in_ready = 1 in the first cycle after reset deassertion.

Verification
REQ-036 SHALL cover a single integer write: push {res=0x0000_00AB, rd=5, fp=0}, rf_busy=0 -> next cycle xrf_we=1, rf_waddr=5, rf_wdata=0xAB, retire_count=1.
REQ-037 SHALL cover x0 suppression: push {rd=0, fp=0, res=0x1234} -> xrf_we=0, frf_we=0, retire_count still increments to 1.
REQ-038 SHALL cover a backpressure fill: rf_busy=1, push two entries -> in_ready=0, a third in_valid is ignored; release rf_busy -> both entries written in order in 2 consecutive cycles, then in_ready=1.
REQ-039 SHALL cover the NaN sticky flag: pop FP entry {rd=3, fp=1, nan=1} -> frf_we=1 and nan_sticky=1; assert clr_flags in the same cycle as a second NaN pop -> nan_sticky stays 1; clr_flags alone -> nan_sticky=0.
REQ-040 SHALL cover counter wrap: preload retire_count to 0xFFFFFFFF (via 2^32 pops or force) plus one pop -> retire_count=0.
REQ-041 SHALL cover reset mid-operation: with 2 entries buffered and rf_busy=1, assert reset asynchronously -> outputs zero before the next clk edge; after release no stale write occurs.
